// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: loader FSM states and stream framing.
// PROGRAM_LOADER_CHECKSUM_EN adds the CHK state (trailing XOR byte check).
package loader_pkg;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [2:0] {
    HDR_LO,
    HDR_HI,
    DATA,
    WRITE,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE,
    ERROR
  } state_e;

  // State entered once all payload words have been written (or when N == 0).
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam state_e TERM_STATE = CHK;
`else
  localparam state_e TERM_STATE = DONE;
`endif

endpackage

// File: rtl/word_assembler.sv
// Little-endian byte-to-word assembler: collects BYTES_PER_WORD bytes, first byte
// lands in bits [7:0]. word_o presents the complete word combinationally on the
// cycle the last byte is shifted in, together with done_o.
import loader_pkg::*;

module word_assembler (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        clear_i,
  input  logic        shift_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        done_o
);

  // Only the three earlier bytes need storage; the fourth is taken straight from byte_i.
  logic [23:0] bytes_q;
  logic [1:0]  cnt_q;

  // Shift register and byte counter; synchronous clear has priority over a shift.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bytes_q <= '0;
      cnt_q   <= '0;
    end else if (clear_i) begin
      bytes_q <= '0;
      cnt_q   <= '0;
    end else if (shift_i) begin
      bytes_q <= {byte_i, bytes_q[23:8]};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

  // Assembled word and completion pulse on the final byte of each word.
  always_comb begin
    word_o = {byte_i, bytes_q};
    done_o = shift_i && (cnt_q == 2'(BYTES_PER_WORD - 1));
  end

endmodule

// File: rtl/program_loader.sv
// Byte-stream instruction loader: 16-bit LE word count, then N LE 32-bit words,
// each written to instruction memory at word_index*4. Optional trailing XOR
// checksum byte when PROGRAM_LOADER_CHECKSUM_EN is defined.
import loader_pkg::*;

module program_loader #(
  parameter int unsigned MAX_WORDS = 512,
  parameter int unsigned ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  input  logic              restart,
  output logic [ADDR_W-1:0] addr_ext,
  output logic              wen_ext,
  output logic [31:0]       wdata_ext,
  output logic              cpu_enable,
  output logic              busy,
  output logic              error
);

  state_e            state_q, state_d;
  logic              hs;
  logic [7:0]        n_lo_q;
  logic [15:0]       n_q;
  logic [15:0]       hdr_n;
  logic [15:0]       idx_q;
  logic [15:0]       idx_next;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       asm_word;
  logic              asm_done;
  logic              data_shift;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q;
`endif

  assign hs         = s_valid && s_ready;
  assign hdr_n      = {s_data, n_lo_q};
  assign idx_next   = idx_q + 16'd1;
  // A restart drops any byte offered in the same cycle.
  assign data_shift = hs && (state_q == DATA) && !restart;

  word_assembler u_asm (
    .clk     (clk),
    .arst_n  (arst_n),
    .clear_i (restart),
    .shift_i (data_shift),
    .byte_i  (s_data),
    .word_o  (asm_word),
    .done_o  (asm_done)
  );

  // State register.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= HDR_LO;
    else         state_q <= state_d;
  end

  // Next-state logic; restart overrides every transition.
  always_comb begin
    state_d = state_q;
    if (restart) begin
      state_d = HDR_LO;
    end else begin
      unique case (state_q)
        HDR_LO: if (hs) state_d = HDR_HI;
        HDR_HI: begin
          if (hs) begin
            if (32'(hdr_n) > MAX_WORDS) state_d = ERROR;
            else if (hdr_n == 16'd0)    state_d = TERM_STATE;
            else                        state_d = DATA;
          end
        end
        DATA:   if (asm_done) state_d = WRITE;
        WRITE:  state_d = (idx_next < n_q) ? DATA : TERM_STATE;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        CHK:    if (hs) state_d = (s_data == csum_q) ? DONE : ERROR;
`endif
        DONE:   state_d = DONE;
        ERROR:  state_d = ERROR;
        default: state_d = HDR_LO;
      endcase
    end
  end

  // Header capture, word index, write address/data holding registers and checksum.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      n_lo_q  <= '0;
      n_q     <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else if (restart) begin
      idx_q   <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      if (hs && state_q == HDR_LO) n_lo_q <= s_data;
      if (hs && state_q == HDR_HI) n_q    <= hdr_n;
      // Load the write bus on the final byte so WRITE presents it one cycle later.
      if (asm_done) begin
        addr_q  <= ADDR_W'(idx_q) << $clog2(BYTES_PER_WORD);
        wdata_q <= asm_word;
      end
      if (state_q == WRITE) idx_q <= idx_next;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      if (data_shift) csum_q <= csum_q ^ s_data;
`endif
    end
  end

  // Output decode from the registered state.
  always_comb begin
    s_ready    = 1'b0;
    busy       = 1'b0;
    wen_ext    = 1'b0;
    cpu_enable = 1'b0;
    error      = 1'b0;
    unique case (state_q)
      HDR_LO: s_ready = 1'b1;
      HDR_HI: begin s_ready = 1'b1; busy = 1'b1; end
      DATA:   begin s_ready = 1'b1; busy = 1'b1; end
      WRITE:  begin wen_ext = 1'b1; busy = 1'b1; end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      CHK:    begin s_ready = 1'b1; busy = 1'b1; end
`endif
      DONE:   cpu_enable = 1'b1;
      ERROR:  error = 1'b1;
      default: ;
    endcase
  end

  assign addr_ext  = addr_q;
  assign wdata_ext = wdata_q;

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter MAX_WORDS, default 512: instruction-memory capacity in 32-bit words, matching 9-bit word addressing.
REQ-002 Parameter ADDR_W, default 64: width of addr_ext.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 arst_n  input  1  reset, asynchronous assertion, active-low.
REQ-005 s_valid  input  1  byte-stream valid.
REQ-006 s_data  input  8  byte-stream payload.
REQ-007 s_ready  output  1  byte accepted on a cycle with s_valid && s_ready.
REQ-008 restart  input  1  synchronous request to abort or finish, then reload.
REQ-009 addr_ext  output  ADDR_W  instruction-memory external byte address.
REQ-010 wen_ext  output  1  instruction-memory external write strobe.
REQ-011 wdata_ext  output  32  instruction word to write.
REQ-012 cpu_enable  output  1  run enable for the processor core.
REQ-013 busy  output  1  high while a load is in progress.
REQ-014 error  output  1  sticky load-failure flag.

Function
REQ-015 The stream format shall be: 16-bit word count N (low byte first), then N words of 4 bytes each, least-significant byte first.
REQ-016 The state machine shall have the states HDR_LO, HDR_HI, DATA, WRITE, CHK, DONE and ERROR.
REQ-017 s_ready shall be 1 in HDR_LO, HDR_HI, DATA and CHK, and 0 in WRITE, DONE and ERROR.
REQ-018 HDR_LO shall go to HDR_HI when a byte is accepted.
REQ-019 HDR_HI shall go to ERROR if N > MAX_WORDS, to the terminal state if N == 0, and to DATA otherwise.
REQ-020 The terminal state shall be DONE, or CHK when checksum checking is compiled in.
REQ-021 DATA shall shift bytes into a 32-bit word; acceptance of the 4th byte shall move to WRITE.
REQ-022 WRITE shall last exactly one cycle with wen_ext=1, addr_ext = word_index*4 (zero-extended) and wdata_ext = the assembled word.
REQ-023 WRITE shall then increment word_index and go to DATA if word_index+1 < N, otherwise to the terminal state.
REQ-024 The latency from the 4th byte handshake to wen_ext shall be 1 cycle.
REQ-025 wen_ext shall never be asserted outside WRITE; addr_ext and wdata_ext shall hold their last values otherwise.
REQ-026 cpu_enable shall be 1 only in DONE (registered) and shall fall in the same cycle DONE is left.
REQ-027 busy shall be 1 in HDR_HI, DATA, WRITE and CHK, and also in HDR_LO after the first byte of a load has been accepted.
REQ-028 restart in any state shall go to HDR_LO and clear word_index, the byte counter, the checksum and error; restart overrides a simultaneous byte handshake, which shall be dropped.
REQ-029 ERROR shall be left only via restart or reset; error shall be 1 exactly while in ERROR.
REQ-030 s_valid without s_ready shall have no effect; s_data shall be sampled only on a handshake.

Reset
REQ-031 While arst_n=0: state=HDR_LO, word_index=0, all counters and the checksum 0, wen_ext=0, cpu_enable=0, busy=0, error=0, addr_ext=0, wdata_ext=0.
REQ-032 Reset asserted mid-load shall abort the load with no further write strobes; words already written shall remain in memory.

Configuration
REQ-033 With PROGRAM_LOADER_CHECKSUM_EN defined: the running XOR of all N*4 payload bytes shall be compared in CHK against one trailing byte; a match shall go to DONE and a mismatch to ERROR.
REQ-034 Without PROGRAM_LOADER_CHECKSUM_EN: the CHK state and the XOR register shall be absent, and the terminal state shall be DONE.

Structure
REQ-035 A shared package loader_pkg shall hold the state enum typedef, HDR_BYTES=2 and BYTES_PER_WORD=4.
REQ-036 One sub-module, word_assembler, shall implement the 4-byte little-endian shift, the byte counter and the word-complete pulse; all other logic shall be in program_loader.

Verification
REQ-037 Bytes 02 00 13 00 00 00 93 00 10 00 with s_valid held high -> writes (0x0, 0x00000013) then (0x4, 0x00100093), each a 1-cycle wen_ext; cpu_enable=1 one cycle after the second write (checksum build off).
REQ-038 Header 00 00 -> no wen_ext pulse; cpu_enable=1 in the cycle after the HDR_HI handshake.
REQ-039 Header 01 02 (N=513) -> error=1, s_ready=0, no wen_ext pulse; restart -> error=0, state=HDR_LO.
REQ-040 Checksum build, payload 01 02 03 04 with trailer 04 -> DONE; the same payload with trailer 05 -> ERROR and cpu_enable stays 0.
REQ-041 s_valid toggled randomly 50% during a 3-word load -> identical write sequence; no byte lost or duplicated.
REQ-042 arst_n pulsed low after the 2nd data byte -> all outputs reach their reset values asynchronously; a subsequent full stream loads correctly starting at address 0.
